serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
Bit-serial N-bit subtractor; the inverse-operation companion to the team's 1-bit ripple adder cell.
- Accepts parallel operands A and B on a start pulse.
- Computes A-B one bit per clock, LSB first, through a single full-subtractor stage with a borrow flip-flop.
- Streams the difference bits out serially, then presents the parallel result with a final borrow and a one-cycle done pulse.
- Used wherever area matters more than latency, e.g. serial datapaths and counters in the TP designs.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured at the accepting edge
b  input  WIDTH  subtrahend, captured at the accepting edge
busy  output  1  high while in RUN
d_bit  output  1  current serial difference bit (LSB first)
d_valid  output  1  d_bit qualifier
diff  output  WIDTH  parallel result, held until next completion
bout  output  1  final borrow (1 when a<b unsigned), held with diff
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0:
  - state=IDLE, internal counter and shift registers cleared, borrow flip-flop cleared.
  - busy=0, d_bit=0, d_valid=0, diff=0, bout=0, done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load a and b into shift registers, borrow=0, cnt=0, go to RUN, busy=1.
  - On an edge with start=0: remain in IDLE.
- RUN: at each edge, with a0/b0 the current LSBs of the shift registers and br the borrow flip-flop:
  - d = a0^b0^br.
  - br_next = (~a0&b0) | (~(a0^b0)&br).
  - d_bit<=d, d_valid<=1.
  - Shift both operand registers right by 1; shift d into the MSB of the result shift register; cnt<=cnt+1.
- Completion: on the edge where cnt==WIDTH-1:
  - diff<=completed result (including the current bit), bout<=br_next.
  - done<=1, busy<=0, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, d_valid still 1 carrying the MSB.
  - Next edge: done<=0, d_valid<=0, go to IDLE.
  - start high in DONE is ignored; the requester must re-assert it in IDLE.
- Latency: if start is accepted at edge T0, result bits are produced at edges T1..T_WIDTH and done is high from T_WIDTH to T_WIDTH+1. The next start can be accepted at T_WIDTH+2 at the earliest.
- Serial stream: d_valid is high for exactly WIDTH consecutive cycles, LSB first; the last cycle coincides with done.
- start while busy or in DONE: ignored; operands are not re-sampled and the in-flight result is unaffected.
- a and b may change freely after the accepting edge.
- diff/bout change only at completion or reset; they are never cleared by start.
- Arithmetic: unsigned modulo 2^WIDTH; diff = (a-b) mod 2^WIDTH; bout = (a<b).
- WIDTH=1: RUN lasts a single edge, then DONE.
- Reset mid-RUN: immediate abort to the reset values; no done pulse; the partial result is discarded.

Test Plan:
1. Reset with rst_n=0 held for 3 cycles -> all outputs 0, busy=0. Then WIDTH=8, a=100, b=37, start pulsed 1 cycle -> d_valid for 8 cycles with bits 1,1,1,1,1,1,0,0. done at T8 with diff=63, bout=0. busy high T1..T7 only.
2. Borrow cases: a=5, b=9 -> diff=8'hFC, bout=1. a=8'h00, b=8'hFF -> diff=8'h01, bout=1. a=8'hFF, b=8'h00 -> diff=8'hFF, bout=0. a=b=8'hA5 -> diff=0, bout=0.
3. Back-to-back transactions with start held high continuously:
   - Transactions are accepted only in IDLE, one every WIDTH+2 cycles.
   - start in DONE is not accepted.
   - Each result is correct, and diff holds its value between done pulses.
4. Operand and start changes mid-operation: change a/b and pulse start during RUN -> result still reflects the operands captured at T0, and no extra transaction occurs.
5. Reset mid-operation: assert rst_n=0 asynchronously at cycle 4 of RUN -> outputs go to 0 immediately without waiting for a clock edge, and no done pulse occurs. A subsequent run with a=20, b=3 gives diff=17.
6. WIDTH=1 instance: all 4 combos (a,b) = 00, 01, 10, 11 -> (diff,bout) = (0,0), (1,1), (1,0), (0,0). done arrives 1 edge after acceptance.

Source files
------------

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
// Bit-serial unsigned subtractor. Captures parallel operands a and b on a
// start request and computes a-b one bit per clock, LSB first, through a
// single full-subtractor stage plus a borrow flip-flop. Each difference bit
// is streamed out on d_bit/d_valid. When the last bit is produced, the full
// parallel result and final borrow are registered on diff/bout and a
// one-cycle done pulse is raised.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while idle
//   a        in   [WIDTH] minuend, captured at the accepting edge
//   b        in   [WIDTH] subtrahend, captured at the accepting edge
//   busy     out  high while bits are being computed
//   d_bit    out  current serial difference bit (LSB first)
//   d_valid  out  qualifies d_bit; high for exactly WIDTH cycles per run
//   diff     out  [WIDTH] parallel result, held until the next completion
//   bout     out  final borrow (1 when a < b unsigned), held with diff
//   done     out  one-cycle completion pulse, coincides with the MSB on d_bit
// ---------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             d_bit,
  output logic             d_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  // Bit counter is kept at least one bit wide so WIDTH=1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor stage working on the current LSBs and the stored borrow.
  assign a0      = a_sr[0];
  assign b0      = b_sr[0];
  assign d       = a0 ^ b0 ^ br;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

  // New bit enters at the MSB so that after WIDTH shifts the first (LSB)
  // bit has walked down to position 0. Written as a shift of the
  // concatenation so that it needs no special case for WIDTH=1.
  assign res_next = WIDTH'({d, res_sr} >> 1);

  // Control FSM and datapath. Operands are only sampled in IDLE, so start
  // pulses during RUN or DONE have no effect on the in-flight result, and
  // diff/bout are only ever written at completion (or cleared by reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      d_bit   <= 1'b0;
      d_valid <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          d_bit   <= d;
          d_valid <= 1'b1;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          br      <= br_next;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            diff  <= res_next;
            bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          // MSB stays on d_bit for this one cycle alongside done.
          done    <= 1'b0;
          d_valid <= 1'b0;
          d_bit   <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          d_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
// Self-checking bench for serial_sub. Drives an 8-bit instance through a
// table of directed vectors plus back-to-back, mid-run disturbance and
// mid-run reset sequences, and a 1-bit instance through all operand combos.
// ---------------------------------------------------------------------------
module tb_serial_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic bout;
  } vec1_t;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       d_bit;
  logic       d_valid;
  logic [7:0] diff;
  logic       bout;
  logic       done;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       d_bit1;
  logic       d_valid1;
  logic [0:0] diff1;
  logic       bout1;
  logic       done1;

  int         checks;
  int         failures;
  logic [7:0] prev_diff;

  vec_t       vecs[7];
  vec1_t      vecs1[4];

  serial_sub #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .d_bit   (d_bit),
    .d_valid (d_valid),
    .diff    (diff),
    .bout    (bout),
    .done    (done)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .a       (a1),
    .b       (b1),
    .busy    (busy1),
    .d_bit   (d_bit1),
    .d_valid (d_valid1),
    .diff    (diff1),
    .bout    (bout1),
    .done    (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full 8-bit transaction; optionally disturbs start/a/b during RUN.
  task automatic applyStimulus(input vec_t v, input bit disturb);
    @(negedge clk);
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~v.a;
    b     = v.b ^ 8'h5A;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_dvalid", 32'(d_valid), 32'd0);
    checkOutput("accept_diff_held", 32'(diff), 32'(prev_diff));
    for (int k = 1; k <= 8; k++) begin
      if (disturb && k == 3) begin
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
      end
      @(posedge clk);
      #1;
      if (disturb && k == 3) start = 1'b0;
      checkOutput("run_dvalid", 32'(d_valid), 32'd1);
      checkOutput("run_dbit", 32'(d_bit), 32'(v.diff[k-1]));
      checkOutput("run_done", 32'(done), 32'(k == 8));
      checkOutput("run_busy", 32'(busy), 32'(k < 8));
      if (k < 8) checkOutput("run_diff_held", 32'(diff), 32'(prev_diff));
    end
    checkOutput("result_diff", 32'(diff), 32'(v.diff));
    checkOutput("result_bout", 32'(bout), 32'(v.bout));
    @(posedge clk);
    #1;
    checkOutput("post_done", 32'(done), 32'd0);
    checkOutput("post_dvalid", 32'(d_valid), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_diff_held", 32'(diff), 32'(v.diff));
    prev_diff = v.diff;
    if (disturb) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        checkOutput("no_extra_txn", 32'(busy), 32'd0);
      end
    end
  endtask

  // One transaction on the 1-bit instance: done follows acceptance by one edge.
  task automatic applyStimulusW1(input vec1_t v);
    @(negedge clk);
    a1     = v.a;
    b1     = v.b;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checkOutput("w1_accept_busy", 32'(busy1), 32'd1);
    checkOutput("w1_accept_done", 32'(done1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("w1_done", 32'(done1), 32'd1);
    checkOutput("w1_dvalid", 32'(d_valid1), 32'd1);
    checkOutput("w1_dbit", 32'(d_bit1), 32'(v.diff));
    checkOutput("w1_diff", 32'(diff1), 32'(v.diff));
    checkOutput("w1_bout", 32'(bout1), 32'(v.bout));
    checkOutput("w1_busy", 32'(busy1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("w1_done_fall", 32'(done1), 32'd0);
    checkOutput("w1_dvalid_fall", 32'(d_valid1), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   p;
    int   n;

    checks    = 0;
    failures  = 0;
    prev_diff = 8'h00;

    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bout: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   diff: 8'hFC,  bout: 1'b1};
    vecs[2] = '{a: 8'h00,  b: 8'hFF,  diff: 8'h01,  bout: 1'b1};
    vecs[3] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF,  bout: 1'b0};
    vecs[4] = '{a: 8'hA5,  b: 8'hA5,  diff: 8'h00,  bout: 1'b0};
    vecs[5] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F,  bout: 1'b0};
    vecs[6] = '{a: 8'h01,  b: 8'h02,  diff: 8'hFF,  bout: 1'b1};

    vecs1[0] = '{a: 1'b0, b: 1'b0, diff: 1'b0, bout: 1'b0};
    vecs1[1] = '{a: 1'b0, b: 1'b1, diff: 1'b1, bout: 1'b1};
    vecs1[2] = '{a: 1'b1, b: 1'b0, diff: 1'b1, bout: 1'b0};
    vecs1[3] = '{a: 1'b1, b: 1'b1, diff: 1'b0, bout: 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dbit", 32'(d_bit), 32'd0);
    checkOutput("rst_dvalid", 32'(d_valid), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_w1_busy", 32'(busy1), 32'd0);
    checkOutput("rst_w1_done", 32'(done1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], 1'b0);

    // Back-to-back with start held high: one acceptance per 10 cycles
    $display("[TB] back-to-back");
    @(negedge clk);
    a     = vecs[1].a;
    b     = vecs[1].b;
    start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      #1;
      p = t % 10;
      n = t / 10;
      checkOutput("b2b_busy", 32'(busy), 32'(p < 8));
      checkOutput("b2b_done", 32'(done), 32'(p == 8));
      checkOutput("b2b_dvalid", 32'(d_valid), 32'(p >= 1 && p <= 8));
      if (p < 8) begin
        checkOutput("b2b_diff_held", 32'(diff), 32'(prev_diff));
      end else begin
        checkOutput("b2b_diff", 32'(diff), 32'(vecs[n+1].diff));
        checkOutput("b2b_bout", 32'(bout), 32'(vecs[n+1].bout));
      end
      if (p == 8) prev_diff = vecs[n+1].diff;
      if (p == 9) begin
        if (n < 2) begin
          a = vecs[n+2].a;
          b = vecs[n+2].b;
        end else begin
          start = 1'b0;
        end
      end
    end

    // Operand and start changes mid-run
    $display("[TB] mid-run disturbance");
    applyStimulus(vecs[0], 1'b1);
    applyStimulus(vecs[6], 1'b1);

    // Asynchronous reset mid-run
    $display("[TB] reset mid-run");
    @(negedge clk);
    a     = 8'd77;
    b     = 8'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_dbit", 32'(d_bit), 32'd0);
    checkOutput("arst_dvalid", 32'(d_valid), 32'd0);
    checkOutput("arst_diff", 32'(diff), 32'd0);
    checkOutput("arst_bout", 32'(bout), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("arst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    prev_diff = 8'h00;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("arst_stays_idle", 32'(done | busy | d_valid), 32'd0);
    end
    v = '{a: 8'd20, b: 8'd3, diff: 8'd17, bout: 1'b0};
    applyStimulus(v, 1'b0);

    // 1-bit instance
    $display("[TB] WIDTH=1 instance");
    for (int i = 0; i < 4; i++) applyStimulusW1(vecs1[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
